// File: rtl/cla_slice_sequencer_if.sv
// Bus bundle between cla_slice_sequencer, its requester/consumer and the attached narrow CLA.
// Optional out_ovf exists only when ADD_OVERFLOW_EN is defined.
interface cla_slice_sequencer_if #(
  parameter int DATA_WID  = 32,
  parameter int SLICE_WID = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_WID-1:0]  in_a;
  logic [DATA_WID-1:0]  in_b;
  logic                 in_cin;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_WID-1:0]  out_sum;
  logic                 out_cout;
  logic [SLICE_WID-1:0] slice_a;
  logic [SLICE_WID-1:0] slice_b;
  logic                 slice_cin;
  logic [SLICE_WID-1:0] slice_sum;
  logic                 slice_cout;
`ifdef ADD_OVERFLOW_EN
  logic                 out_ovf;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, slice_sum, slice_cout,
    output in_ready, out_valid, out_sum, out_cout, slice_a, slice_b, slice_cin
`ifdef ADD_OVERFLOW_EN
    , output out_ovf
`endif
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, slice_sum, slice_cout,
    input  in_ready, out_valid, out_sum, out_cout, slice_a, slice_b, slice_cin
`ifdef ADD_OVERFLOW_EN
    , input out_ovf
`endif
  );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Feeds a SLICE_WID-bit CLA one slice per cycle (LSB first) to build a DATA_WID-bit add.
// Define ADD_OVERFLOW_EN to add the signed overflow flag out_ovf.
module cla_slice_sequencer #(
  parameter int DATA_WID  = 32,
  parameter int SLICE_WID = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cla_slice_sequencer_if.slave   bus
);

  localparam int NUM_SLICES = DATA_WID / SLICE_WID;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  generate
    if ((DATA_WID % SLICE_WID) != 0) begin : g_bad_width
      $error("DATA_WID must be an integer multiple of SLICE_WID");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic [DATA_WID-1:0]   opa_q, opa_d;
  logic [DATA_WID-1:0]   opb_q, opb_d;
  logic [DATA_WID-1:0]   res_q, res_d;
  logic [DATA_WID-1:0]   sum_q, sum_d;
  logic                  cout_q, cout_d;
`ifdef ADD_OVERFLOW_EN
  logic                  ovf_q, ovf_d;
`endif

  logic                          inReady;
  logic                          running;
  logic [DATA_WID+SLICE_WID-1:0] resWide;
  logic [DATA_WID-1:0]           resNext;

  // Each new slice enters at the MSB end, so after NUM_SLICES shifts slice 0 sits at the LSB.
  assign resWide = {bus.slice_sum, res_q};
  assign resNext = resWide[DATA_WID+SLICE_WID-1:SLICE_WID];

  assign running       = rst_n && (state_q == RUN);
  assign inReady       = rst_n && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign bus.in_ready  = inReady;
  assign bus.out_valid = rst_n && (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.slice_a   = running ? opa_q[SLICE_WID-1:0] : '0;
  assign bus.slice_b   = running ? opb_q[SLICE_WID-1:0] : '0;
  assign bus.slice_cin = running ? carry_q : 1'b0;
`ifdef ADD_OVERFLOW_EN
  assign bus.out_ovf   = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADD_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
        if (bus.in_valid && inReady) begin
          opa_d   = bus.in_a;
          opb_d   = bus.in_b;
          carry_d = bus.in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = resNext;
        carry_d = bus.slice_cout;
        opa_d   = opa_q >> SLICE_WID;
        opb_d   = opb_q >> SLICE_WID;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_SLICES - 1)) begin
          state_d = DONE;
          sum_d   = resNext;
          cout_d  = bus.slice_cout;
`ifdef ADD_OVERFLOW_EN
          // Carry into the MSB recovered from the adder's MSB inputs and sum bit.
          ovf_d   = opa_q[SLICE_WID-1] ^ opb_q[SLICE_WID-1] ^
                    bus.slice_sum[SLICE_WID-1] ^ bus.slice_cout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADD_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
